// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Next-PC and issue controller for the two-stage core. Owns the
//            fetch PC and the EX-stage PC, applies branch/jal/jalr redirects,
//            squashes wrong-path fetches with bubbles, and provides debug
//            halt / single-step / resume plus a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      pc_src,
    input  logic [PC_W-1:0] branch_addr,
    input  logic [PC_W-1:0] jal_addr,
    input  logic [PC_W-1:0] jalr_addr,
    input  logic            halt_req,
    input  logic            step_req,
    input  logic            resume_req,
    output logic [PC_W-1:0] pc_f,
    output logic [PC_W-1:0] pc_ex,
    output logic            ex_valid,
    output logic            halted,
    output logic [31:0]     retire_count
);

    localparam logic [1:0]      c_SRC_SEQ    = 2'b00;
    localparam logic [1:0]      c_SRC_BRANCH = 2'b01;
    localparam logic [1:0]      c_SRC_JAL    = 2'b10;
    localparam logic [PC_W-1:0] c_PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PC_W-1:0]   r_pc_f;
    logic [PC_W-1:0]   w_pc_f_nxt;
    logic [PC_W-1:0]   r_pc_ex;
    logic              r_ex_valid;
    logic              w_ex_valid_nxt;
    logic              r_halted;
    logic [31:0]       r_retire_count;
    logic              w_redirect;
    logic [PC_W-1:0]   w_target;
    logic [PC_W-1:0]   w_pc_f_inc;

    // Redirect decode: only a real instruction in EX may steer the fetch PC.
    always_comb begin
        w_redirect = r_ex_valid && (pc_src != c_SRC_SEQ);
        w_pc_f_inc = r_pc_f + c_PC_ONE;
        case (pc_src)
            c_SRC_BRANCH: w_target = branch_addr;
            c_SRC_JAL:    w_target = jal_addr;
            default:      w_target = jalr_addr;
        endcase
    end

    // Next-state, next fetch PC and next issue-valid selection.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_f_nxt     = r_pc_f;
        w_ex_valid_nxt = 1'b0;
        case (r_state)
            S_RUN: begin
                if (halt_req) begin
                    // In-flight EX instruction still completes; a redirect
                    // it requests is honoured so resume fetches the target.
                    w_state_nxt = S_HALT;
                    if (w_redirect) begin
                        w_pc_f_nxt = w_target;
                    end
                end else if (w_redirect) begin
                    // Wrong-path word at pc_f is dropped by issuing a bubble.
                    w_pc_f_nxt = w_target;
                end else begin
                    w_pc_f_nxt     = w_pc_f_inc;
                    w_ex_valid_nxt = 1'b1;
                end
            end
            S_HALT: begin
                if (resume_req) begin
                    w_state_nxt    = S_RUN;
                    w_pc_f_nxt     = w_pc_f_inc;
                    w_ex_valid_nxt = 1'b1;
                end else if (step_req) begin
                    w_state_nxt    = S_STEP;
                    w_pc_f_nxt     = w_pc_f_inc;
                    w_ex_valid_nxt = 1'b1;
                end
            end
            S_STEP: begin
                // The stepped instruction is in EX now; return to HALT and
                // follow its redirect if it has one.
                w_state_nxt = S_HALT;
                if (w_redirect) begin
                    w_pc_f_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // State, PC pipeline, issue-valid and retire counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_RUN;
            r_pc_f         <= RESET_PC;
            r_pc_ex        <= RESET_PC;
            r_ex_valid     <= 1'b0;
            r_halted       <= 1'b0;
            r_retire_count <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc_f     <= w_pc_f_nxt;
            r_pc_ex    <= r_pc_f;
            r_ex_valid <= w_ex_valid_nxt;
            r_halted   <= (w_state_nxt == S_HALT);
            if (r_ex_valid) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    assign pc_f         = r_pc_f;
    assign pc_ex        = r_pc_ex;
    assign ex_valid     = r_ex_valid;
    assign halted       = r_halted;
    assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed-vector bench for fetch_sequencer. The driver applies one
//            input vector per cycle and queues the hand-computed post-edge
//            outputs; an independent monitor pops and compares after each
//            rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int PC_W = 12;

    typedef struct {
        logic [PC_W-1:0] pc_f;
        logic [PC_W-1:0] pc_ex;
        logic            ex_valid;
        logic            halted;
        logic [31:0]     retire;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      pc_src;
    logic [PC_W-1:0] branch_addr;
    logic [PC_W-1:0] jal_addr;
    logic [PC_W-1:0] jalr_addr;
    logic            halt_req;
    logic            step_req;
    logic            resume_req;
    logic [PC_W-1:0] pc_f;
    logic [PC_W-1:0] pc_ex;
    logic            ex_valid;
    logic            halted;
    logic [31:0]     retire_count;

    exp_t exp_q[$];
    int   n_applied;
    int   n_miscompare;
    int   n_pushed;
    logic drive_done;

    fetch_sequencer #(
        .PC_W    (PC_W),
        .RESET_PC(12'h000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_src      (pc_src),
        .branch_addr (branch_addr),
        .jal_addr    (jal_addr),
        .jalr_addr   (jalr_addr),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .resume_req  (resume_req),
        .pc_f        (pc_f),
        .pc_ex       (pc_ex),
        .ex_valid    (ex_valid),
        .halted      (halted),
        .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector before the next rising edge and queue its expected result.
    task automatic vec(input logic r, input logic [1:0] src, input logic h,
                       input logic s, input logic res,
                       input logic [PC_W-1:0] e_pf, input logic [PC_W-1:0] e_pex,
                       input logic e_v, input logic e_h, input logic [31:0] e_rc);
        exp_t e;
        @(negedge clk);
        rst_n      = r;
        pc_src     = src;
        halt_req   = h;
        step_req   = s;
        resume_req = res;
        e.pc_f     = e_pf;
        e.pc_ex    = e_pex;
        e.ex_valid = e_v;
        e.halted   = e_h;
        e.retire   = e_rc;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Monitor: after every rising edge, compare outputs with the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_applied++;
            if (pc_f !== e.pc_f || pc_ex !== e.pc_ex || ex_valid !== e.ex_valid ||
                halted !== e.halted || retire_count !== e.retire) begin
                n_miscompare++;
                $display("FAIL vec%0d: got pc_f=%h pc_ex=%h v=%b h=%b rc=%0d, want pc_f=%h pc_ex=%h v=%b h=%b rc=%0d",
                         n_applied, pc_f, pc_ex, ex_valid, halted, retire_count,
                         e.pc_f, e.pc_ex, e.ex_valid, e.halted, e.retire);
            end
        end
    end

    initial begin
        n_applied    = 0;
        n_miscompare = 0;
        n_pushed     = 0;
        drive_done   = 1'b0;
        rst_n        = 1'b0;
        pc_src       = 2'b00;
        halt_req     = 1'b0;
        step_req     = 1'b0;
        resume_req   = 1'b0;
        branch_addr  = 12'h040;
        jal_addr     = 12'h100;
        jalr_addr    = 12'hFFE;

        //   rst src    h  s  r    pc_f    pc_ex   v  h  rc
        // Reset state
        vec(0, 2'b00, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0);
        vec(0, 2'b00, 1, 1, 1, 12'h000, 12'h000, 0, 0, 0);
        // Sequential run from reset
        vec(1, 2'b00, 0, 0, 0, 12'h001, 12'h000, 1, 0, 0);
        vec(1, 2'b00, 0, 0, 0, 12'h002, 12'h001, 1, 0, 1);
        vec(1, 2'b00, 0, 0, 0, 12'h003, 12'h002, 1, 0, 2);
        vec(1, 2'b00, 0, 0, 0, 12'h004, 12'h003, 1, 0, 3);
        vec(1, 2'b00, 0, 0, 0, 12'h005, 12'h004, 1, 0, 4);
        vec(1, 2'b00, 0, 0, 0, 12'h006, 12'h005, 1, 0, 5);
        // Taken branch from pc_ex=5, then jalr ignored during the bubble
        vec(1, 2'b01, 0, 0, 0, 12'h040, 12'h006, 0, 0, 6);
        vec(1, 2'b11, 0, 0, 0, 12'h041, 12'h040, 1, 0, 6);
        vec(1, 2'b00, 0, 0, 0, 12'h042, 12'h041, 1, 0, 7);
        vec(1, 2'b00, 0, 0, 0, 12'h043, 12'h042, 1, 0, 8);
        // Halt together with a taken jal: target kept, jal counted
        vec(1, 2'b10, 1, 0, 0, 12'h100, 12'h043, 0, 1, 9);
        vec(1, 2'b10, 1, 0, 0, 12'h100, 12'h100, 0, 1, 9);
        vec(1, 2'b00, 0, 0, 0, 12'h100, 12'h100, 0, 1, 9);
        vec(1, 2'b00, 0, 0, 0, 12'h100, 12'h100, 0, 1, 9);
        vec(1, 2'b00, 1, 0, 0, 12'h100, 12'h100, 0, 1, 9);
        // step_req held: one instruction every two cycles
        vec(1, 2'b00, 0, 1, 0, 12'h101, 12'h100, 1, 0, 9);
        vec(1, 2'b00, 0, 1, 0, 12'h101, 12'h101, 0, 1, 10);
        vec(1, 2'b00, 0, 1, 0, 12'h102, 12'h101, 1, 0, 10);
        // Branch taken by the stepped instruction
        vec(1, 2'b01, 0, 0, 1, 12'h040, 12'h102, 0, 1, 11);
        // Resume has priority over step
        vec(1, 2'b00, 0, 1, 1, 12'h041, 12'h040, 1, 0, 11);
        vec(1, 2'b00, 0, 0, 0, 12'h042, 12'h041, 1, 0, 12);
        // jalr to top of PC space, then wrap to zero
        vec(1, 2'b11, 0, 0, 0, 12'hFFE, 12'h042, 0, 0, 13);
        vec(1, 2'b00, 0, 0, 0, 12'hFFF, 12'hFFE, 1, 0, 13);
        vec(1, 2'b00, 0, 0, 0, 12'h000, 12'hFFF, 1, 0, 14);
        vec(1, 2'b00, 0, 0, 0, 12'h001, 12'h000, 1, 0, 15);
        // Halt without redirect, step, then reset during STEP
        vec(1, 2'b00, 1, 0, 0, 12'h001, 12'h001, 0, 1, 16);
        vec(1, 2'b00, 0, 1, 0, 12'h002, 12'h001, 1, 0, 16);
        vec(0, 2'b00, 1, 1, 1, 12'h000, 12'h000, 0, 0, 0);
        vec(1, 2'b00, 0, 0, 0, 12'h001, 12'h000, 1, 0, 0);
        vec(1, 2'b00, 0, 0, 0, 12'h002, 12'h001, 1, 0, 1);
        drive_done = 1'b1;
    end

    // Wait for the scoreboard to drain (bounded), then report.
    initial begin
        int guard;
        guard = 0;
        while (!(drive_done && exp_q.size() == 0) && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0 || n_applied != n_pushed || n_applied == 0) begin
            n_miscompare++;
            $display("FAIL drain: got %0d checked with %0d pending, want %0d checked with 0 pending",
                     n_applied, exp_q.size(), n_pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Next-PC and issue controller for the two-stage core (Fetch → Decode/Execute, with Writeback one cycle behind). It owns the fetch PC and the EX-stage PC, and applies branch/jump redirects from the control unit. It squashes wrong-path fetches by issuing bubbles, and adds debug halt/single-step/resume plus a retired-instruction counter. EX consumes `ex_valid` to substitute a NOP (32'h0) for the fetched word when low.

## Interface
Parameters:
- PC_W, 12, width of word-addressed PC
- RESET_PC, 0, PC loaded on reset

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- pc_src  input  2  from control unit for EX instruction: 00 seq, 01 branch, 10 jal, 11 jalr
- branch_addr  input  PC_W  branch target for EX instruction
- jal_addr  input  PC_W  jal target for EX instruction
- jalr_addr  input  PC_W  jalr target for EX instruction
- halt_req  input  1  debug: request halt (level, sampled each edge)
- step_req  input  1  debug: issue one instruction while halted
- resume_req  input  1  debug: leave halt
- pc_f  output  PC_W  address presented to instruction RAM
- pc_ex  output  PC_W  PC of the instruction currently in EX
- ex_valid  output  1  EX holds a real instruction; 0 = bubble (NOP)
- halted  output  1  high in HALT state
- retire_count  output  32  instructions completed in EX

## Operation
- States: RUN, HALT, STEP. Reset → RUN.
- redirect = ex_valid && pc_src != 00. target is branch_addr, jal_addr or jalr_addr per pc_src. pc_src is ignored when ex_valid=0.
- Every edge (not in reset):
  - pc_ex <= pc_f.
  - If ex_valid=1, retire_count increments, wrapping modulo 2^32.
- RUN:
  - redirect: pc_f <= target, ex_valid <= 0. This squashes the wrong-path word at pc_f.
  - else: pc_f <= pc_f+1 (mod 2^PC_W), ex_valid <= 1.
  - halt_req=1: state <= HALT and ex_valid <= 0. pc_f takes target if redirect, else holds. The in-flight EX instruction still completes and is counted.
- HALT:
  - ex_valid <= 0 and pc_f holds, except when resume_req or step_req is accepted (below).
  - resume_req=1 (priority over step_req): state <= RUN, and the RUN no-redirect issue rules apply at this edge (pc_f+1, ex_valid <= 1).
  - else step_req=1: state <= STEP, ex_valid <= 1, pc_f <= pc_f+1.
  - halt_req has no effect in HALT.
- STEP: state <= HALT, ex_valid <= 0. pc_f <= target if redirect, else holds. halt_req, step_req and resume_req are ignored.
- step_req held high yields one instruction per two cycles (HALT/STEP alternation).
- halted = (state == HALT).

## Timing
- Reset values:
  - pc_f = RESET_PC, pc_ex = RESET_PC
  - ex_valid = 0, halted = 0, retire_count = 0, state RUN
- Reset has priority over all requests and clears an in-progress halt or step.
- First post-reset edge: ex_valid <= 1, pc_ex <= RESET_PC, pc_f <= RESET_PC+1.
- Issue latency: the word at pc_f is in EX (ex_valid=1) one cycle later.
- Taken redirect costs exactly one bubble cycle. The target instruction is in EX two cycles after the redirecting instruction enters EX.
- Halt latency: halted rises one edge after halt_req is sampled in RUN.
- Back-to-back redirects cannot occur, because a bubble always follows a redirect.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then run sequential: release rst_n; pc_src=00 → after 5 edges pc_f=5, pc_ex=4, retire_count=4, and ex_valid=1 from cycle 1.
- Taken branch: EX at pc_ex=3 with pc_src=01, branch_addr=0x40 → next cycle ex_valid=0, pc_f=0x40; following cycle ex_valid=1, pc_ex=0x40, pc_f=0x41; retire_count skips the squashed word.
- jalr with ex_valid=0: drive pc_src=11 during a bubble → no redirect, pc_f increments normally.
- Halt/step/resume: halt_req at pc_f=8 → halted=1, pc_f=8 frozen for 10 cycles, retire_count frozen. Pulse step_req → one cycle later pc_ex=8, ex_valid=1, then HALT with pc_f=9. resume_req → RUN from pc_f=9.
- Simultaneous halt_req and taken jal (jal_addr=0x100) → HALT with pc_f=0x100; the jal instruction is counted.
- PC wrap and mid-operation reset: with PC_W=12, run from pc_f=0xFFF → pc_f=0x000 next. Assert rst_n=0 during STEP → all outputs return to reset values on that edge, state RUN.
